// File: rtl/ili934x_wr_arb.sv
// Packet-granular arbiter merging N_REQ LCD write-item streams {is_cmd, byte} into one write engine.
// Requester 0 (init sequencer) has strict priority; requesters 1..N_REQ-1 share a round-robin pointer.
module ili934x_wr_arb #(
  parameter int N_REQ         = 3,
  parameter int STALL_TIMEOUT = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0][8:0]      req_item,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       out_valid,
  output logic [8:0]                 out_item,
  input  logic                       out_ready,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       timeout_err
);
  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(STALL_TIMEOUT + 2);

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t        state_r, state_s;
  logic [GW-1:0] grant_id_r, grant_id_s, rr_ptr_r, rr_ptr_s;
  logic [GW-1:0] winner_s, cand_s, next_rr_s;
  logic [CW-1:0] stall_cnt_r, stall_cnt_s;
  logic          timeout_err_r, timeout_err_s;
  logic          found_s, busy_s, g_valid_s, g_last_s, xfer_s, stall_hit_s, release_s;
  int            cand_idx_s;

  assign busy_s    = (state_r == S_GRANT);
  assign g_valid_s = req_valid[grant_id_r];
  assign g_last_s  = req_last[grant_id_r];
  assign xfer_s    = busy_s && g_valid_s && out_ready;
  assign stall_hit_s = (STALL_TIMEOUT > 0) && busy_s && !g_valid_s &&
                       ((int'(stall_cnt_r) + 1) >= STALL_TIMEOUT);
  assign release_s = (xfer_s && g_last_s) || stall_hit_s;
  // Pointer moves just past the releasing requester, skipping index 0.
  assign next_rr_s = (int'(grant_id_r) == N_REQ - 1) ? GW'(1) : grant_id_r + GW'(1);

  // Winner selection: requester 0 first, else upward search from rr_ptr over 1..N_REQ-1.
  always_comb begin
    found_s    = 1'b0;
    winner_s   = '0;
    cand_idx_s = 0;
    cand_s     = '0;
    if (req_valid[0]) begin
      found_s  = 1'b1;
      winner_s = '0;
    end else begin
      for (int i = 0; i < N_REQ - 1; i++) begin
        cand_idx_s = int'(rr_ptr_r) + i;
        cand_idx_s = (cand_idx_s >= N_REQ) ? cand_idx_s - (N_REQ - 1) : cand_idx_s;
        cand_s     = GW'(cand_idx_s);
        if (!found_s && req_valid[cand_s]) begin
          found_s  = 1'b1;
          winner_s = cand_s;
        end else begin
          found_s  = found_s;
        end
      end
    end
  end

  // Next-state, grant, pointer and stall-counter logic.
  always_comb begin
    state_s       = state_r;
    grant_id_s    = grant_id_r;
    rr_ptr_s      = rr_ptr_r;
    stall_cnt_s   = '0;
    timeout_err_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (found_s) begin
          state_s    = S_GRANT;
          grant_id_s = winner_s;
        end else begin
          state_s    = S_IDLE;
        end
      end
      S_GRANT: begin
        if (!g_valid_s && (STALL_TIMEOUT > 0)) begin
          stall_cnt_s = stall_cnt_r + CW'(1);
        end else begin
          stall_cnt_s = '0;
        end
        if (release_s) begin
          state_s       = S_IDLE;
          stall_cnt_s   = '0;
          timeout_err_s = stall_hit_s;
          rr_ptr_s      = (grant_id_r != '0) ? next_rr_s : rr_ptr_r;
        end else begin
          state_s       = S_GRANT;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= S_IDLE;
      grant_id_r    <= '0;
      rr_ptr_r      <= GW'(1);
      stall_cnt_r   <= '0;
      timeout_err_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      grant_id_r    <= grant_id_s;
      rr_ptr_r      <= rr_ptr_s;
      stall_cnt_r   <= stall_cnt_s;
      timeout_err_r <= timeout_err_s;
    end
  end

  // Zero-latency forward from the owner; out_item always comes from a selected input.
  always_comb begin
    req_ready = '0;
    if (busy_s) begin
      req_ready[grant_id_r] = out_ready;
    end else begin
      req_ready = '0;
    end
  end

  assign out_valid   = busy_s && g_valid_s;
  assign out_item    = req_item[grant_id_r];
  assign grant_id    = grant_id_r;
  assign busy        = busy_s;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_ili934x_wr_arb.sv
// Directed bench for ili934x_wr_arb: requester queues drive stimulus, a scoreboard monitor
// compares every forwarded item against hand-ordered expectations.
module tb_ili934x_wr_arb;
  localparam int N = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid, req_last, req_ready, en;
  logic [N-1:0][8:0] req_item;
  logic            out_valid, out_ready, busy, timeout_err;
  logic [8:0]      out_item;
  logic [1:0]      grant_id;

  logic [9:0]  q0[$], q1[$], q2[$];
  logic [11:0] exq[$];
  int checks = 0;
  int errors = 0;

  ili934x_wr_arb #(.N_REQ(N), .STALL_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_item(req_item), .req_last(req_last),
    .req_ready(req_ready), .out_valid(out_valid), .out_item(out_item), .out_ready(out_ready),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pkt(input int r, input logic lst, input logic cmd, input logic [7:0] b);
    case (r)
      0:       q0.push_back({lst, cmd, b});
      1:       q1.push_back({lst, cmd, b});
      default: q2.push_back({lst, cmd, b});
    endcase
  endtask

  task automatic exp_item(input int r, input logic lst, input logic cmd, input logic [7:0] b);
    exq.push_back({2'(r), lst, cmd, b});
  endtask

  task automatic drive();
    logic [9:0] w0, w1, w2;
    w0 = (q0.size() > 0) ? q0[0] : 10'h000;
    w1 = (q1.size() > 0) ? q1[0] : 10'h000;
    w2 = (q2.size() > 0) ? q2[0] : 10'h000;
    req_valid = {en[2] && (q2.size() > 0), en[1] && (q1.size() > 0), en[0] && (q0.size() > 0)};
    req_item  = {w2[8:0], w1[8:0], w0[8:0]};
    req_last  = {w2[9], w1[9], w0[9]};
    #1;
  endtask

  // One clock: record handshakes before the edge, retire accepted items after it.
  task automatic tick();
    logic [N-1:0] f;
    @(negedge clk);
    f = req_valid & req_ready;
    @(posedge clk);
    #1;
    if (f[0]) void'(q0.pop_front());
    if (f[1]) void'(q1.pop_front());
    if (f[2]) void'(q2.pop_front());
    drive();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || q0.size() > 0 || q1.size() > 0 || q2.size() > 0) && n < 60) begin
      tick();
      n++;
    end
    chk(name, (n < 60), 1);
  endtask

  // Scoreboard monitor: every transfer must match the next expected {grant, last, item}.
  always @(negedge clk) begin
    logic [11:0] e;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %0h with empty expectation queue",
                 {grant_id, req_last[grant_id], out_item});
      end else begin
        e = exq.pop_front();
        if ({grant_id, req_last[grant_id], out_item} !== e) begin
          errors++;
          $display("FAIL sb_item: got %0h expected %0h", {grant_id, req_last[grant_id], out_item}, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    en = '1;
    out_ready = 1'b1;
    drive();
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_grant", grant_id, 0);
    rst = 1'b0;

    // Req 1 three-item packet; arbitration cycle then items on cycles 1..3.
    pkt(1, 0, 1, 8'h2A); pkt(1, 0, 0, 8'h00); pkt(1, 1, 0, 8'h00);
    exp_item(1, 0, 1, 8'h2A); exp_item(1, 0, 0, 8'h00); exp_item(1, 1, 0, 8'h00);
    drive();
    chk("v1_arb_busy", busy, 0);
    chk("v1_arb_valid", out_valid, 0);
    tick();
    chk("v1_busy", busy, 1);
    chk("v1_grant", grant_id, 1);
    chk("v1_ready", req_ready, 3'b010);
    tick(); tick();
    chk("v1_busy_c3", busy, 1);
    tick();
    chk("v1_idle_c4", busy, 0);

    // Req 1 and 2 both pending; rr_ptr=2 so grants go 2,1,2,1 with idle gaps.
    pkt(1, 1, 1, 8'h11); pkt(1, 1, 1, 8'h12);
    pkt(2, 1, 1, 8'h21); pkt(2, 1, 1, 8'h22);
    exp_item(2, 1, 1, 8'h21); exp_item(1, 1, 1, 8'h11);
    exp_item(2, 1, 1, 8'h22); exp_item(1, 1, 1, 8'h12);
    drive();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("v2_busy", busy, 1);
      chk("v2_grant", grant_id, (k % 2 == 0) ? 2 : 1);
      tick();
      chk("v2_gap", busy, 0);
    end

    // Req 0 raised mid-packet of req 2: no preemption, then req 0 beats req 1 with rr_ptr=1.
    pkt(2, 0, 1, 8'h2C); pkt(2, 0, 0, 8'h55); pkt(2, 1, 0, 8'h66); pkt(1, 1, 1, 8'h30);
    exp_item(2, 0, 1, 8'h2C); exp_item(2, 0, 0, 8'h55); exp_item(2, 1, 0, 8'h66);
    exp_item(0, 1, 1, 8'h01); exp_item(1, 1, 1, 8'h30);
    drive();
    tick();
    chk("v3_grant2", grant_id, 2);
    tick();
    pkt(0, 1, 1, 8'h01);
    drive();
    chk("v3_hold", grant_id, 2);
    chk("v3_r0_ready", req_ready[0], 0);
    tick(); tick();
    chk("v3_gap", busy, 0);
    tick();
    chk("v3_grant0", grant_id, 0);
    tick(); tick();
    chk("v3_grant1", grant_id, 1);
    wait_idle("v3_done");

    // Backpressure for 10 cycles: item held, no state change, no timeout.
    pkt(1, 0, 1, 8'h2B); pkt(1, 0, 0, 8'h01); pkt(1, 1, 0, 8'h02);
    exp_item(1, 0, 1, 8'h2B); exp_item(1, 0, 0, 8'h01); exp_item(1, 1, 0, 8'h02);
    drive();
    tick();
    chk("v4_grant", grant_id, 1);
    tick();
    out_ready = 1'b0;
    drive();
    for (int k = 0; k < 10; k++) begin
      chk("v4_item", out_item, 9'h001);
      chk("v4_ready", req_ready[1], 0);
      chk("v4_busy", busy, 1);
      chk("v4_timeout", timeout_err, 0);
      tick();
    end
    out_ready = 1'b1;
    drive();
    wait_idle("v4_done");

    // Req 1 stalls after its first item: forced release after 4 stalled cycles.
    pkt(1, 0, 1, 8'h2A); pkt(1, 0, 0, 8'h10); pkt(1, 1, 0, 8'h20);
    exp_item(1, 0, 1, 8'h2A);
    drive();
    tick();
    chk("v5_grant1", grant_id, 1);
    tick();
    en[1] = 1'b0;
    pkt(2, 1, 1, 8'h40);
    exp_item(2, 1, 1, 8'h40);
    drive();
    chk("v5_stall_busy", busy, 1);
    chk("v5_stall_to", timeout_err, 0);
    chk("v5_r2_ready", req_ready[2], 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("v5_stall_busy", busy, 1);
      chk("v5_stall_to", timeout_err, 0);
    end
    tick();
    chk("v5_timeout", timeout_err, 1);
    chk("v5_release", busy, 0);
    q1.delete();
    en[1] = 1'b1;
    drive();
    tick();
    chk("v5_pulse_end", timeout_err, 0);
    chk("v5_busy2", busy, 1);
    chk("v5_grant2", grant_id, 2);
    wait_idle("v5_done");

    // Move rr_ptr to 2, then reset during a req 2 packet; afterwards req 1 wins.
    pkt(1, 1, 1, 8'h32);
    exp_item(1, 1, 1, 8'h32);
    drive();
    wait_idle("v6_pre");
    pkt(2, 0, 1, 8'h2C); pkt(2, 0, 0, 8'h77); pkt(2, 1, 0, 8'h78);
    exp_item(2, 0, 1, 8'h2C);
    drive();
    tick();
    chk("v6_grant2", grant_id, 2);
    tick();
    rst = 1'b1;
    out_ready = 1'b0;
    drive();
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    q2.delete();
    pkt(1, 1, 1, 8'h31);
    pkt(2, 0, 1, 8'h2C); pkt(2, 0, 0, 8'h77); pkt(2, 1, 0, 8'h78);
    exp_item(1, 1, 1, 8'h31);
    exp_item(2, 0, 1, 8'h2C); exp_item(2, 0, 0, 8'h77); exp_item(2, 1, 0, 8'h78);
    drive();
    chk("v6_out_valid", out_valid, 0);
    chk("v6_busy", busy, 0);
    chk("v6_req_ready", req_ready, 0);
    chk("v6_grant_rst", grant_id, 0);
    tick();
    chk("v6_grant1", grant_id, 1);
    wait_idle("v6_done");

    chk("sb_drained", exq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
